// File: rtl/stopwatch_pkg.sv
// Shared types and button map for the stopwatch control slice.
// Holds the FSM state encoding and the fixed button bit positions.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUNNING  = 2'b01,
        PAUSED   = 2'b10,
        LAP_VIEW = 2'b11
    } sw_state_t;

    localparam int BTN_START = 0;
    localparam int BTN_STOP  = 1;
    localparam int BTN_LAP   = 2;
    localparam int BTN_CLEAR = 3;
    localparam int BTN_MODE  = 4;

endpackage

// File: rtl/stopwatch_ctrl_fsm_long_press_detect.sv
// Long-press detector: counts cycles a level is held while enabled.
// Ports: clk, rst, enable, level in; fire out (one cycle per hold).
module long_press_detect #(
    parameter int CYCLES = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic level,
    output logic fire
);

    localparam int W = $clog2(CYCLES);
    localparam logic [W-1:0] LAST = W'(CYCLES - 1);

    logic [W-1:0] hold_cnt;
    logic         done;
    logic         active;

    assign active = enable & level;
    // done blocks a re-fire while the counter sits saturated at LAST
    assign fire = active & ~done & (hold_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            done     <= 1'b0;
        end else if (!active) begin
            hold_cnt <= '0;
            done     <= 1'b0;
        end else begin
            if (hold_cnt != LAST)
                hold_cnt <= hold_cnt + 1'b1;
            if (fire)
                done <= 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl_fsm.sv
// Stopwatch control FSM: press detection, arbitration, lap timer.
// Ports: clk, rst, btn_level in; run_en, clear_pulse, lap_latch, disp_freeze, mode, state out.
module stopwatch_ctrl_fsm
    import stopwatch_pkg::*;
#(
    parameter int NUM_BTN           = 5,
    parameter int LAP_HOLD_CYCLES   = 100000000,
    parameter int LONG_PRESS_CYCLES = 100000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_level,
    output logic               run_en,
    output logic               clear_pulse,
    output logic               lap_latch,
    output logic               disp_freeze,
    output logic               mode,
    output sw_state_t          state
);

    localparam int LAP_W = $clog2(LAP_HOLD_CYCLES);
    localparam logic [LAP_W-1:0] LAP_LAST = LAP_W'(LAP_HOLD_CYCLES - 1);

    logic [NUM_BTN-1:0] btn_q;
    logic [NUM_BTN-1:0] ev;
    logic [LAP_W-1:0]   lap_cnt;
    logic               win_stop;
    logic               win_start;
    logic               win_lap;
    logic               clr_fire;
    logic               clr_enable;

    assign ev = btn_level & ~btn_q;

    // STOP > START > LAP; a losing event is dropped outright
    assign win_stop  = ev[BTN_STOP];
    assign win_start = ev[BTN_START] & ~ev[BTN_STOP];
    assign win_lap   = ev[BTN_LAP] & ~ev[BTN_STOP] & ~ev[BTN_START];

    assign clr_enable = (state == IDLE) || (state == PAUSED);

    long_press_detect #(
        .CYCLES (LONG_PRESS_CYCLES)
    ) u_clear_hold (
        .clk    (clk),
        .rst    (rst),
        .enable (clr_enable),
        .level  (btn_level[BTN_CLEAR]),
        .fire   (clr_fire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            run_en      <= 1'b0;
            clear_pulse <= 1'b0;
            lap_latch   <= 1'b0;
            disp_freeze <= 1'b0;
            mode        <= 1'b0;
            lap_cnt     <= '0;
            // all ones: a button held through reset needs a fresh press
            btn_q       <= '1;
        end else begin
            btn_q       <= btn_level;
            clear_pulse <= 1'b0;
            lap_latch   <= 1'b0;
            mode        <= mode ^ ev[BTN_MODE];
            unique case (state)
                IDLE: begin
                    if (win_start) begin
                        state  <= RUNNING;
                        run_en <= 1'b1;
                    end else if (clr_fire) begin
                        clear_pulse <= 1'b1;
                    end
                end
                RUNNING: begin
                    if (win_stop) begin
                        state  <= PAUSED;
                        run_en <= 1'b0;
                    end else if (win_lap) begin
                        state       <= LAP_VIEW;
                        lap_latch   <= 1'b1;
                        disp_freeze <= 1'b1;
                        lap_cnt     <= LAP_LAST;
                    end
                end
                LAP_VIEW: begin
                    if (win_stop) begin
                        state       <= PAUSED;
                        run_en      <= 1'b0;
                        disp_freeze <= 1'b0;
                    end else if (win_lap) begin
                        lap_latch <= 1'b1;
                        lap_cnt   <= LAP_LAST;
                    end else if (lap_cnt == '0) begin
                        state       <= RUNNING;
                        disp_freeze <= 1'b0;
                    end else begin
                        lap_cnt <= lap_cnt - 1'b1;
                    end
                end
                PAUSED: begin
                    if (win_start) begin
                        state  <= RUNNING;
                        run_en <= 1'b1;
                    end else if (clr_fire) begin
                        clear_pulse <= 1'b1;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
